// File: rtl/cram_pkg.sv
// rtl/cram_pkg.sv - shared types and sizing helpers for the CRAM bitstream loader and fpgacell
package cram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } cram_state_t;

  // Per-cell CRAM length: switch box, four connection boxes, then {mode, LUT}.
  function automatic int cell_cfg_bits(input int bus_width, input int le_in,
                                       input int le_out, input int lut);
    return bus_width * bus_width + 2 * bus_width * (le_in + le_out) + 1 + lut;
  endfunction

  function automatic int cram_nwords(input int chain_len, input int word_width);
    return (chain_len + word_width - 1) / word_width;
  endfunction

  function automatic int cram_pad(input int chain_len, input int word_width);
    return cram_nwords(chain_len, word_width) * word_width - chain_len;
  endfunction

endpackage

// File: rtl/cram_loader_if.sv
// rtl/cram_loader_if.sv - control, bitstream, chain and readback signals of the CRAM loader
interface cram_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  start;
  logic                  abort;
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;
  logic                  cfg_sdo;
  logic                  cfg_en;
  logic                  cfg_sdi;
  logic [WORD_WIDTH-1:0] rb_data;
  logic                  rb_valid;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, abort, word_data, word_valid, cfg_sdi,
    input  word_ready, cfg_sdo, cfg_en, rb_data, rb_valid, busy, done, err
  );

  modport slave (
    input  start, abort, word_data, word_valid, cfg_sdi,
    output word_ready, cfg_sdo, cfg_en, rb_data, rb_valid, busy, done, err
  );
endinterface

// File: rtl/cram_rb_packer.sv
// rtl/cram_rb_packer.sv - deserializes chain-tail bits into readback words
module cram_rb_packer #(
  parameter int WORD_WIDTH = 8,
  parameter int FIRST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  sdi,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid
);
  localparam int CW = $clog2(WORD_WIDTH + 1);

  logic [CW-1:0]         cnt_q;
  logic [WORD_WIDTH-1:0] acc_q;
  logic                  first_q;
  logic [WORD_WIDTH-1:0] acc_next;
  logic [CW-1:0]         target;

  assign acc_next = {acc_q[WORD_WIDTH-2:0], sdi};
  // The short first word comes out with its padding bits as leading zeros.
  assign target   = first_q ? CW'(FIRST_LEN) : CW'(WORD_WIDTH);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      first_q  <= 1'b1;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (clr) begin
        cnt_q   <= '0;
        acc_q   <= '0;
        first_q <= 1'b1;
      end else if (en) begin
        if (cnt_q + CW'(1) == target) begin
          rb_data  <= acc_next;
          rb_valid <= 1'b1;
          acc_q    <= '0;
          cnt_q    <= '0;
          first_q  <= 1'b0;
        end else begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cram_loader.sv
// rtl/cram_loader.sv - serializes a bitstream into the fpgacell CRAM chain and captures readback
module cram_loader
  import cram_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int CHAIN_LEN  = 161
) (
  input  logic         clk,
  input  logic         nrst,
  cram_loader_if.slave bus
);
  localparam int NWORDS = cram_nwords(CHAIN_LEN, WORD_WIDTH);
  localparam int PAD    = cram_pad(CHAIN_LEN, WORD_WIDTH);
  localparam int WCW    = $clog2(NWORDS + 1);
  localparam int BCW    = $clog2(WORD_WIDTH + 1);
  localparam logic [WCW-1:0] NWORDS_C   = WCW'(NWORDS);
  localparam logic [BCW-1:0] FIRST_BITS = BCW'(WORD_WIDTH - PAD);
  localparam logic [BCW-1:0] FULL_BITS  = BCW'(WORD_WIDTH);

  cram_state_t           state_q, state_d;
  logic [WCW-1:0]        words_q, words_d;
  logic [BCW-1:0]        bits_q, bits_d;
  logic [WORD_WIDTH-1:0] sh_q, sh_d;
  logic                  sdo_q, sdo_d;
  logic                  en_q, en_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  start_ok;
  logic                  abort_ok;
  logic                  first_word;
  logic                  last_bit;
  logic [WORD_WIDTH-1:0] aligned;

  // bits_q counts the unsent bits of the current word, including the one on cfg_sdo;
  // ready on the last bit lets the next word follow without a bubble.
  assign bus.word_ready = (state_q == ST_LOAD) && (words_q != '0) && (bits_q <= BCW'(1));
  assign accept         = bus.word_ready && bus.word_valid;
  assign start_ok       = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign abort_ok       = (state_q != ST_IDLE) && bus.abort;
  assign first_word     = (words_q == NWORDS_C);
  assign aligned        = first_word ? (bus.word_data << PAD) : bus.word_data;
  assign last_bit       = (words_q == '0) && (bits_q == BCW'(1));

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    bits_d  = bits_q;
    sh_d    = sh_q;
    sdo_d   = sdo_q;
    en_d    = en_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_LOAD;
          words_d = NWORDS_C;
          bits_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          sdo_d   = aligned[WORD_WIDTH-1];
          sh_d    = aligned << 1;
          en_d    = 1'b1;
          bits_d  = first_word ? FIRST_BITS : FULL_BITS;
          words_d = words_q - WCW'(1);
        end else if (bits_q > BCW'(1)) begin
          sdo_d  = sh_q[WORD_WIDTH-1];
          sh_d   = sh_q << 1;
          bits_d = bits_q - BCW'(1);
        end else begin
          sdo_d  = 1'b0;
          en_d   = 1'b0;
          bits_d = '0;
        end
        if (last_bit) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_ok) begin
      state_d = ST_IDLE;
      words_d = '0;
      bits_d  = '0;
      sdo_d   = 1'b0;
      en_d    = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      words_q <= '0;
      bits_q  <= '0;
      sh_q    <= '0;
      sdo_q   <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      sdo_q   <= sdo_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  assign bus.cfg_sdo = sdo_q;
  assign bus.cfg_en  = en_q;
  assign bus.err     = err_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);

  cram_rb_packer #(
    .WORD_WIDTH(WORD_WIDTH),
    .FIRST_LEN (WORD_WIDTH - PAD)
  ) u_rb_packer (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (start_ok || abort_ok),
    .en      (en_q),
    .sdi     (bus.cfg_sdi),
    .rb_data (bus.rb_data),
    .rb_valid(bus.rb_valid)
  );

endmodule

// File: tb/tb_cram_loader.sv
// tb/tb_cram_loader.sv - directed bench for cram_loader with a shift-register chain model
module tb_cram_loader;
  import cram_pkg::*;

  localparam int SW  = 4;
  localparam int SL  = 10;
  localparam int FW  = 8;
  localparam int FL  = cell_cfg_bits(8, 4, 1, 16);
  localparam int NWF = cram_nwords(FL, FW);

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  cram_loader_if #(.WORD_WIDTH(SW)) bus_s ();
  cram_loader_if #(.WORD_WIDTH(FW)) bus_f ();

  cram_loader #(.WORD_WIDTH(SW), .CHAIN_LEN(SL)) dut_s (.clk(clk), .nrst(nrst), .bus(bus_s));
  cram_loader #(.WORD_WIDTH(FW), .CHAIN_LEN(FL)) dut_f (.clk(clk), .nrst(nrst), .bus(bus_f));

  logic [SL-1:0] chain_s;
  logic [FL-1:0] chain_f;
  logic          preload_s;
  logic [SL-1:0] preload_val_s;

  always @(posedge clk) begin
    if (preload_s) chain_s <= preload_val_s;
    else if (bus_s.cfg_en) chain_s <= {chain_s[SL-2:0], bus_s.cfg_sdo};
  end
  always @(posedge clk) begin
    if (bus_f.cfg_en) chain_f <= {chain_f[FL-2:0], bus_f.cfg_sdo};
  end
  assign bus_s.cfg_sdi = chain_s[SL-1];
  assign bus_f.cfg_sdi = chain_f[FL-1];

  int passed = 0;
  int total  = 0;

  logic [SL-1:0]     res_sdo;
  logic [3*SW-1:0]   res_rb;
  int                res_en, res_first, res_last, res_done, res_nrb;
  logic              res_en_done, res_rb_done, res_busy_done, res_err_start;
  logic [NWF*FW-1:0] resf_rb;
  int                resf_en, resf_first, resf_last, resf_done, resf_nrb;

  task automatic load_s(input logic [3*SW-1:0] words, input int gap, input int poke_at,
                        input bit poke_start, input bit poke_abort);
    int idx;
    int gapcnt;
    bit pending;
    bit fin;
    idx = 0; gapcnt = 0; pending = 1'b0; fin = 1'b0;
    res_sdo = '0; res_rb = '0; res_en = 0; res_first = -1; res_last = -1;
    res_done = 0; res_nrb = 0; res_en_done = 1'b1; res_rb_done = 1'b0; res_busy_done = 1'b0;
    @(negedge clk); bus_s.start = 1'b1;
    @(negedge clk); bus_s.start = 1'b0;
    res_err_start = bus_s.err;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      bus_s.start = 1'b0;
      if (bus_s.cfg_en) begin
        res_sdo = {res_sdo[SL-2:0], bus_s.cfg_sdo};
        if (res_first < 0) res_first = cyc;
        res_last = cyc;
        res_en++;
      end
      if (bus_s.rb_valid) begin
        res_rb = {res_rb[2*SW-1:0], bus_s.rb_data};
        res_nrb++;
      end
      if (bus_s.done) begin
        res_done++;
        res_en_done = bus_s.cfg_en; res_rb_done = bus_s.rb_valid; res_busy_done = bus_s.busy;
        fin = 1'b1;
      end
      if (poke_at > 0 && bus_s.cfg_en && res_en == poke_at) begin
        bus_s.start = poke_start;
        bus_s.abort = poke_abort;
        if (poke_abort) fin = 1'b1;
      end
      if (pending) begin idx++; gapcnt = gap; end
      bus_s.word_valid = (idx < 3) && (gapcnt == 0);
      bus_s.word_data  = (idx < 3) ? words[(2-idx)*SW +: SW] : '0;
      if (bus_s.word_ready && gapcnt > 0) gapcnt--;
      pending = bus_s.word_valid && bus_s.word_ready;
      @(negedge clk);
    end
    bus_s.word_valid = 1'b0;
  endtask

  task automatic load_f(input logic [NWF*FW-1:0] words);
    int idx;
    bit pending;
    bit fin;
    idx = 0; pending = 1'b0; fin = 1'b0;
    resf_rb = '0; resf_en = 0; resf_first = -1; resf_last = -1; resf_done = 0; resf_nrb = 0;
    @(negedge clk); bus_f.start = 1'b1;
    @(negedge clk); bus_f.start = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (bus_f.cfg_en) begin
        if (resf_first < 0) resf_first = cyc;
        resf_last = cyc;
        resf_en++;
      end
      if (bus_f.rb_valid) begin
        resf_rb = {resf_rb[(NWF-1)*FW-1:0], bus_f.rb_data};
        resf_nrb++;
      end
      if (bus_f.done) begin resf_done++; fin = 1'b1; end
      if (pending) idx++;
      bus_f.word_valid = (idx < NWF);
      bus_f.word_data  = (idx < NWF) ? words[(NWF-1-idx)*FW +: FW] : '0;
      pending = bus_f.word_valid && bus_f.word_ready;
      @(negedge clk);
    end
    bus_f.word_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus_s.word_ready, bus_s.cfg_sdo, bus_s.cfg_en, bus_s.rb_data, bus_s.rb_valid,
         bus_s.busy, bus_s.done, bus_s.err} !== '0)
      $display("FAIL reset_small: outputs not all zero (busy=%b en=%b err=%b rdy=%b)",
               bus_s.busy, bus_s.cfg_en, bus_s.err, bus_s.word_ready);
    else passed++;
    total++;
    if ({bus_f.word_ready, bus_f.cfg_sdo, bus_f.cfg_en, bus_f.rb_data, bus_f.rb_valid,
         bus_f.busy, bus_f.done, bus_f.err} !== '0)
      $display("FAIL reset_full: outputs not all zero (busy=%b en=%b err=%b)",
               bus_f.busy, bus_f.cfg_en, bus_f.err);
    else passed++;
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    load_s(12'h3A5, 0, 0, 1'b0, 1'b0);
    total++; if (res_sdo !== 10'b1110100101) $display("FAIL basic_sdo: got %b want 1110100101", res_sdo); else passed++;
    total++; if (res_en !== 10) $display("FAIL basic_en_count: got %0d want 10", res_en); else passed++;
    total++; if (res_last - res_first + 1 !== 10) $display("FAIL basic_contiguous: span %0d want 10", res_last - res_first + 1); else passed++;
    total++; if (res_done !== 1) $display("FAIL basic_done: got %0d pulses want 1", res_done); else passed++;
    total++; if ({res_en_done, res_busy_done} !== 2'b01) $display("FAIL basic_done_cycle: en=%b busy=%b want en=0 busy=1", res_en_done, res_busy_done); else passed++;
    total++; if (bus_s.busy !== 1'b0) $display("FAIL basic_busy_drop: got %b want 0", bus_s.busy); else passed++;
    total++; if (chain_s !== 10'b1110100101) $display("FAIL basic_chain: got %b want 1110100101", chain_s); else passed++;
  endtask

  task automatic test_readback();
    @(negedge clk); preload_s = 1'b1; preload_val_s = 10'b1110100101;
    @(negedge clk); preload_s = 1'b0;
    load_s(12'h0F0, 0, 0, 1'b0, 1'b0);
    total++; if (res_nrb !== 3) $display("FAIL rb_count: got %0d want 3", res_nrb); else passed++;
    total++; if (res_rb !== 12'h3A5) $display("FAIL rb_data: got %h want 3a5", res_rb); else passed++;
    total++; if (res_rb_done !== 1'b1) $display("FAIL rb_last_with_done: got %b want 1", res_rb_done); else passed++;
    total++; if (chain_s !== 10'b0011110000) $display("FAIL rb_chain: got %b want 0011110000", chain_s); else passed++;
  endtask

  task automatic test_throttle();
    load_s(12'h3A5, 3, 0, 1'b0, 1'b0);
    total++; if (res_en !== 10) $display("FAIL throttle_en_count: got %0d want 10", res_en); else passed++;
    total++; if (res_last - res_first + 1 !== 16) $display("FAIL throttle_span: got %0d want 16", res_last - res_first + 1); else passed++;
    total++; if (res_sdo !== 10'b1110100101) $display("FAIL throttle_sdo: got %b want 1110100101", res_sdo); else passed++;
    total++; if (chain_s !== 10'b1110100101) $display("FAIL throttle_chain: got %b want 1110100101", chain_s); else passed++;
  endtask

  task automatic test_abort();
    int stray;
    stray = 0;
    load_s(12'h3A5, 0, 5, 1'b0, 1'b1);
    bus_s.abort = 1'b0;
    total++; if ({bus_s.cfg_en, bus_s.busy, bus_s.err} !== 3'b001) $display("FAIL abort_next_cycle: en/busy/err=%b want 001", {bus_s.cfg_en, bus_s.busy, bus_s.err}); else passed++;
    total++; if (chain_s !== 10'b0010111101) $display("FAIL abort_partial_chain: got %b want 0010111101", chain_s); else passed++;
    for (int i = 0; i < 5; i++) begin
      if (bus_s.done || bus_s.rb_valid || bus_s.cfg_en) stray++;
      @(negedge clk);
    end
    total++; if (stray !== 0) $display("FAIL abort_quiet: got %0d active cycles want 0", stray); else passed++;
    load_s(12'h3A5, 0, 0, 1'b0, 1'b0);
    total++; if (res_err_start !== 1'b0) $display("FAIL abort_err_cleared: got %b want 0", res_err_start); else passed++;
    total++; if (res_done !== 1 || chain_s !== 10'b1110100101) $display("FAIL abort_recover: done=%0d chain=%b want 1 1110100101", res_done, chain_s); else passed++;
  endtask

  task automatic test_start_while_busy();
    load_s(12'h3A5, 0, 4, 1'b1, 1'b0);
    total++; if (res_en !== 10 || res_last - res_first + 1 !== 10) $display("FAIL busy_start_en: count=%0d span=%0d want 10 10", res_en, res_last - res_first + 1); else passed++;
    total++; if (res_done !== 1) $display("FAIL busy_start_done: got %0d want 1", res_done); else passed++;
    total++; if (res_rb !== 12'h3A5) $display("FAIL busy_start_rb: got %h want 3a5", res_rb); else passed++;
  endtask

  task automatic test_nrst_mid_load();
    @(negedge clk); bus_s.start = 1'b1;
    @(negedge clk); bus_s.start = 1'b0; bus_s.word_valid = 1'b1; bus_s.word_data = 4'hA;
    repeat (3) @(negedge clk);
    total++; if ({bus_s.busy, bus_s.cfg_en} !== 2'b11) $display("FAIL nrst_preload_active: busy/en=%b want 11", {bus_s.busy, bus_s.cfg_en}); else passed++;
    nrst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus_s.word_ready, bus_s.cfg_sdo, bus_s.cfg_en, bus_s.rb_data, bus_s.rb_valid,
         bus_s.busy, bus_s.done, bus_s.err} !== '0)
      $display("FAIL nrst_mid_load: busy=%b en=%b err=%b rdy=%b want all 0",
               bus_s.busy, bus_s.cfg_en, bus_s.err, bus_s.word_ready);
    else passed++;
    nrst = 1'b1; bus_s.word_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk); bus_s.start = 1'b1; bus_s.abort = 1'b1;
    @(negedge clk); bus_s.start = 1'b0; bus_s.abort = 1'b0;
    total++; if ({bus_s.busy, bus_s.word_ready, bus_s.err} !== 3'b000) $display("FAIL start_abort_idle: busy/rdy/err=%b want 000", {bus_s.busy, bus_s.word_ready, bus_s.err}); else passed++;
    repeat (2) @(negedge clk);
    total++; if ({bus_s.busy, bus_s.cfg_en} !== 2'b00) $display("FAIL start_abort_stays_idle: busy/en=%b want 00", {bus_s.busy, bus_s.cfg_en}); else passed++;
  endtask

  task automatic test_full_cell();
    logic [NWF*FW-1:0] bs;
    logic [NWF*FW-1:0] want_rb;
    bs = {7'h55, 64'hDEAD_BEEF_0123_4567, 8'hA5, 32'h1357_9BDF, 8'h3C, 32'hCAFE_F00D, 1'b1, 16'h8888};
    load_f(bs);
    total++; if (resf_en !== 161 || resf_last - resf_first + 1 !== 161) $display("FAIL full_en: count=%0d span=%0d want 161 161", resf_en, resf_last - resf_first + 1); else passed++;
    total++; if (resf_done !== 1) $display("FAIL full_done: got %0d want 1", resf_done); else passed++;
    total++; if (chain_f !== bs[FL-1:0]) $display("FAIL full_chain: got %h want %h", chain_f, bs[FL-1:0]); else passed++;
    want_rb = {7'b0, bs[FL-1:0]};
    load_f('0);
    total++; if (resf_nrb !== NWF) $display("FAIL full_rb_count: got %0d want %0d", resf_nrb, NWF); else passed++;
    total++; if (resf_rb !== want_rb) $display("FAIL full_rb_data: got %h want %h", resf_rb, want_rb); else passed++;
    total++; if (chain_f !== '0) $display("FAIL full_chain_zero: got %h want 0", chain_f); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    preload_s = 1'b0; preload_val_s = '0;
    bus_s.start = 1'b0; bus_s.abort = 1'b0; bus_s.word_valid = 1'b0; bus_s.word_data = '0;
    bus_f.start = 1'b0; bus_f.abort = 1'b0; bus_f.word_valid = 1'b0; bus_f.word_data = '0;
    test_reset();
    test_basic_load();
    test_readback();
    test_throttle();
    test_abort();
    test_start_while_busy();
    test_nrst_mid_load();
    test_start_abort_idle();
    test_full_cell();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
